digit_match_ctrl: RTL and testbench

Sequencer for the number-recognition path. On a start pulse it sweeps the shared row address of the ten digit-glyph ROMs (0–9) and the captured-image row buffer. For each digit it accumulates a per-pixel agreement score over the 16×16 frame, then performs a sequential arg-max and reports the best-matching digit and its score. It sits between the image capture buffer and the display/seven-segment logic, and owns the ROMs' recognition-side `addr` port. The display-side port stays with the VGA path.

---
 rtl/numrecog_pkg.sv | 17 +
 rtl/popcount16.sv | 18 +
 rtl/digit_match_ctrl.sv | 165 ++++++++++++++++
 tb/tb_digit_match_ctrl.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/numrecog_pkg.sv
// Shared types and constants for the number-recognition path.
package numrecog_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SCAN   = 2'd1,
    ST_ARGMAX = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam int ROW_W   = 4;
  localparam int SCORE_W = 9;
  localparam int DIG_W   = 4;

  localparam logic [DIG_W-1:0] DIGIT_NONE = 4'hF;

endpackage

// File: rtl/popcount16.sv
// Counts agreeing pixels between two 16-pixel rows (XNOR popcount).
module popcount16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [4:0]  cnt
);

  logic [15:0] agree;

  always_comb begin
    agree = ~(a ^ b);
    cnt   = 5'd0;
    for (int i = 0; i < 16; i++) begin
      cnt = cnt + {4'd0, agree[i]};
    end
  end

endmodule

// File: rtl/digit_match_ctrl.sv
// Glyph-match sequencer: row sweep with per-digit agreement scores, then arg-max.
// Optional build macro MATCH_THRESH_EN rejects results scoring below THRESH.
module digit_match_ctrl
  import numrecog_pkg::*;
#(
  parameter int NUM_DIG = 10,
  parameter int ROWS    = 16,
  parameter int COLS    = 16,
  parameter int THRESH  = 200
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  output logic [ROW_W-1:0]         rom_addr,
  output logic [ROW_W-1:0]         img_addr,
  input  logic [NUM_DIG*COLS-1:0]  rom_rows,
  input  logic [COLS-1:0]          img_row,
  output logic                     busy,
  output logic                     done,
  output logic [DIG_W-1:0]         digit,
  output logic [SCORE_W-1:0]       score,
  output logic                     valid
);

  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);
  localparam logic [DIG_W-1:0] LAST_DIG = DIG_W'(NUM_DIG - 1);

  state_t               state_q, state_d;
  logic [ROW_W-1:0]     addr_q, addr_d;
  logic [SCORE_W-1:0]   acc_q [NUM_DIG];
  logic [SCORE_W-1:0]   acc_d [NUM_DIG];
  logic [DIG_W-1:0]     k_q, k_d;
  logic [SCORE_W-1:0]   best_q, best_d;
  logic [DIG_W-1:0]     best_idx_q, best_idx_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [DIG_W-1:0]     digit_q, digit_d;
  logic [SCORE_W-1:0]   score_q, score_d;
  logic                 valid_q, valid_d;

  logic [4:0]           pc [NUM_DIG];
  logic [SCORE_W-1:0]   cand_best;
  logic [DIG_W-1:0]     cand_idx;

  for (genvar g = 0; g < NUM_DIG; g++) begin : g_pc
    popcount16 u_pc (
      .a   (img_row),
      .b   (rom_rows[g*COLS +: COLS]),
      .cnt (pc[g])
    );
  end

  // Running arg-max step; k=0 seeds with digit 0, strict > keeps the lowest digit on ties.
  always_comb begin
    cand_best = best_q;
    cand_idx  = best_idx_q;
    if (k_q == '0) begin
      cand_best = acc_q[0];
      cand_idx  = '0;
    end else if (acc_q[k_q] > best_q) begin
      cand_best = acc_q[k_q];
      cand_idx  = k_q;
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    acc_d      = acc_q;
    k_d        = k_q;
    best_d     = best_q;
    best_idx_d = best_idx_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    digit_d    = digit_q;
    score_d    = score_q;
    valid_d    = valid_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          for (int d = 0; d < NUM_DIG; d++) acc_d[d] = '0;
          addr_d  = '0;
          busy_d  = 1'b1;
          state_d = ST_SCAN;
        end
      end
      ST_SCAN: begin
        for (int d = 0; d < NUM_DIG; d++) acc_d[d] = acc_q[d] + {4'd0, pc[d]};
        if (addr_q == LAST_ROW) begin
          addr_d  = '0;
          k_d     = '0;
          state_d = ST_ARGMAX;
        end else begin
          addr_d = addr_q + 1'b1;
        end
      end
      ST_ARGMAX: begin
        best_d     = cand_best;
        best_idx_d = cand_idx;
        k_d        = k_q + 1'b1;
        if (k_q == LAST_DIG) begin
          // Result is loaded here so it is already visible during the DONE cycle.
          done_d  = 1'b1;
          score_d = cand_best;
`ifdef MATCH_THRESH_EN
          if (cand_best < SCORE_W'(THRESH)) begin
            valid_d = 1'b0;
            digit_d = DIGIT_NONE;
          end else begin
            valid_d = 1'b1;
            digit_d = cand_idx;
          end
`else
          valid_d = 1'b1;
          digit_d = cand_idx;
`endif
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      for (int d = 0; d < NUM_DIG; d++) acc_q[d] <= '0;
      k_q        <= '0;
      best_q     <= '0;
      best_idx_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      digit_q    <= DIGIT_NONE;
      score_q    <= '0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      acc_q      <= acc_d;
      k_q        <= k_d;
      best_q     <= best_d;
      best_idx_q <= best_idx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      digit_q    <= digit_d;
      score_q    <= score_d;
      valid_q    <= valid_d;
    end
  end

  assign rom_addr = addr_q;
  assign img_addr = addr_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign digit    = digit_q;
  assign score    = score_q;
  assign valid    = valid_q;

endmodule

// File: tb/tb_digit_match_ctrl.sv
// Directed bench for digit_match_ctrl with seven-segment style glyph ROM and image models.
module tb_digit_match_ctrl;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [3:0]   rom_addr, img_addr;
  logic [159:0] rom_rows;
  logic [15:0]  img_row;
  logic         busy, done, valid;
  logic [3:0]   digit;
  logic [8:0]   score;

  int n_checks = 0;
  int n_fail   = 0;

  // 0: real glyphs, 1: all zero, 2: glyph 3 = FFFF, others zero
  int          rom_mode  = 0;
  // 0: image is glyph img_digit, 1: image is img_const on every row
  int          img_mode  = 0;
  int          img_digit = 9;
  logic [15:0] img_const = 16'h0000;

  int dn_cnt, addr_err, busy_err;
  int dn_cyc [4];
  logic [3:0] dn_dig [4];
  logic [8:0] dn_score [4];
  logic       dn_valid [4];

  digit_match_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .rom_addr (rom_addr),
    .img_addr (img_addr),
    .rom_rows (rom_rows),
    .img_row  (img_row),
    .busy     (busy),
    .done     (done),
    .digit    (digit),
    .score    (score),
    .valid    (valid)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] glyph_row(input int d, input logic [3:0] r);
    logic [6:0] seg;
    logic [15:0] row;
    case (d)
      0: seg = 7'b1111110; 1: seg = 7'b0110000; 2: seg = 7'b1101101;
      3: seg = 7'b1111001; 4: seg = 7'b0110011; 5: seg = 7'b1011011;
      6: seg = 7'b1011111; 7: seg = 7'b1110000; 8: seg = 7'b1111111;
      default: seg = 7'b1111011;
    endcase
    row = 16'h0000;
    if (r == 4'd1 || r == 4'd2) begin
      if (seg[6]) row = 16'h1FF8;
    end else if (r >= 4'd3 && r <= 4'd6) begin
      if (seg[1]) row = row | 16'h000C;
      if (seg[5]) row = row | 16'h3000;
    end else if (r == 4'd7 || r == 4'd8) begin
      if (seg[0]) row = 16'h1FF8;
    end else if (r >= 4'd9 && r <= 4'd13) begin
      if (seg[2]) row = row | 16'h000C;
      if (seg[4]) row = row | 16'h3000;
    end else if (r >= 4'd14) begin
      if (seg[3]) row = 16'h1FF8;
    end
    return row;
  endfunction

  always_comb begin
    rom_rows = '0;
    for (int d = 0; d < 10; d++) begin
      if (rom_mode == 0)      rom_rows[d*16 +: 16] = glyph_row(d, rom_addr);
      else if (rom_mode == 2) rom_rows[d*16 +: 16] = (d == 3) ? 16'hFFFF : 16'h0000;
      else                    rom_rows[d*16 +: 16] = 16'h0000;
    end
    img_row = (img_mode == 0) ? glyph_row(img_digit, img_addr) : img_const;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Steps through cycles 1..ncyc after a cycle-0 start, sampling #1 after each edge.
  task automatic observe(input int ncyc, input int s1, input int s2,
                         input int sw_cyc, input int sw_digit, input bit chk_seq);
    dn_cnt = 0; addr_err = 0; busy_err = 0;
    for (int c = 1; c <= ncyc; c++) begin
      @(posedge clk); #1;
      if (done) begin
        if (dn_cnt < 4) begin
          dn_cyc[dn_cnt]   = c;
          dn_dig[dn_cnt]   = digit;
          dn_score[dn_cnt] = score;
          dn_valid[dn_cnt] = valid;
        end
        dn_cnt++;
      end
      if (chk_seq) begin
        if (c <= 16 && (rom_addr != 4'(c - 1) || img_addr != rom_addr)) addr_err++;
        if (c <= 28 && busy != (c <= 27)) busy_err++;
      end
      start = (c == s1 || c == s2);
      if (c == sw_cyc) img_digit = sw_digit;
    end
    start = 1'b0;
  endtask

  task automatic kick();
    @(posedge clk); #1;
    start = 1'b1;
  endtask

  initial begin
    #23 rst = 1'b0;
    #1;
    check("rst_digit", 32'(digit), 32'hF);
    check("rst_score", 32'(score), 0);
    check("rst_valid", 32'(valid), 0);
    check("rst_busy",  32'(busy), 0);
    check("rst_done",  32'(done), 0);
    check("rst_addr",  32'(rom_addr), 0);

    // image = glyph 9
    rom_mode = 0; img_mode = 0; img_digit = 9;
    kick(); observe(35, -1, -1, -1, 0, 1'b1);
    check("g9_ndone", 32'(dn_cnt), 1);
    check("g9_cyc",   32'(dn_cyc[0]), 27);
    check("g9_digit", 32'(dn_dig[0]), 9);
    check("g9_score", 32'(dn_score[0]), 256);
    check("g9_valid", 32'(dn_valid[0]), 1);
    check("g9_addr_seq", 32'(addr_err), 0);
    check("g9_busy", 32'(busy_err), 0);
    check("g9_hold_digit", 32'(digit), 9);

    // all-zero tie: lowest digit wins
    rom_mode = 1; img_mode = 1; img_const = 16'h0000;
    kick(); observe(30, -1, -1, -1, 0, 1'b1);
    check("tie_digit", 32'(dn_dig[0]), 0);
    check("tie_score", 32'(dn_score[0]), 256);
    check("tie_valid", 32'(dn_valid[0]), 1);

    // glyph 3 all ones, image FFF0: 12 agree per row
    rom_mode = 2; img_mode = 1; img_const = 16'hFFF0;
    kick(); observe(30, -1, -1, -1, 0, 1'b1);
    check("thr_score", 32'(dn_score[0]), 192);
`ifdef MATCH_THRESH_EN
    check("thr_digit", 32'(dn_dig[0]), 32'hF);
    check("thr_valid", 32'(dn_valid[0]), 0);
`else
    check("thr_digit", 32'(dn_dig[0]), 3);
    check("thr_valid", 32'(dn_valid[0]), 1);
`endif

    // re-start while busy is dropped
    rom_mode = 0; img_mode = 0; img_digit = 5;
    kick(); observe(60, 5, 27, -1, 0, 1'b1);
    check("drop_ndone", 32'(dn_cnt), 1);
    check("drop_cyc",   32'(dn_cyc[0]), 27);
    check("drop_digit", 32'(dn_dig[0]), 5);
    check("drop_addr_seq", 32'(addr_err), 0);

    // asynchronous reset in the middle of SCAN
    img_digit = 4;
    kick(); observe(10, -1, -1, -1, 0, 1'b1);
    check("mid_busy_pre", 32'(busy), 1);
    #2 rst = 1'b1;
    #1;
    check("arst_busy",  32'(busy), 0);
    check("arst_addr",  32'(rom_addr), 0);
    check("arst_iaddr", 32'(img_addr), 0);
    check("arst_digit", 32'(digit), 32'hF);
    check("arst_score", 32'(score), 0);
    check("arst_valid", 32'(valid), 0);
    check("arst_done",  32'(done), 0);
    @(posedge clk); #2 rst = 1'b0;
    observe(40, -1, -1, -1, 0, 1'b0);
    check("arst_no_done", 32'(dn_cnt), 0);
    kick(); observe(30, -1, -1, -1, 0, 1'b1);
    check("post_rst_cyc",   32'(dn_cyc[0]), 27);
    check("post_rst_digit", 32'(dn_dig[0]), 4);

    // back-to-back: second start at cycle 28 with a new image
    img_digit = 2;
    kick(); observe(62, 28, -1, 28, 7, 1'b1);
    check("b2b_ndone",  32'(dn_cnt), 2);
    check("b2b_cyc0",   32'(dn_cyc[0]), 27);
    check("b2b_dig0",   32'(dn_dig[0]), 2);
    check("b2b_cyc1",   32'(dn_cyc[1]), 55);
    check("b2b_dig1",   32'(dn_dig[1]), 7);
    check("b2b_score1", 32'(dn_score[1]), 256);
    check("b2b_hold",   32'(digit), 7);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
